// File: rtl/jelly3_img_bayer_white_balance_param_ctl.sv
// rtl/jelly3_img_bayer_white_balance_param_ctl.sv - frame-synchronous shadow/live parameter sequencer for Bayer WB
// Optional forced apply on timeout: define JELLY3_IMG_WB_PARAM_CTL_TIMEOUT_EN.
module jelly3_img_bayer_white_balance_param_ctl #(
  parameter int OFFSET_BITS      = 10,
  parameter int COEFF_BITS       = 14,
  parameter int COEFF_Q          = 10,
  parameter int TIMEOUT_BITS     = 24,
  parameter int FRAME_COUNT_BITS = 16,
  parameter bit INIT_ENABLE      = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic                          img_valid,
  input  logic                          img_row_first,
  input  logic                          img_col_first,
  input  logic                          s_enable,
  input  logic [1:0]                    s_phase,
  input  logic [4*OFFSET_BITS-1:0]      s_offset,
  input  logic [4*COEFF_BITS-1:0]       s_coeff,
  input  logic [1:0]                    s_update_mode,
  input  logic                          s_update_req,
  input  logic [TIMEOUT_BITS-1:0]       timeout,
  output logic                          m_enable,
  output logic [1:0]                    m_phase,
  output logic [4*OFFSET_BITS-1:0]      m_offset,
  output logic [4*COEFF_BITS-1:0]       m_coeff,
  output logic                          update_busy,
  output logic                          update_ack,
  output logic                          update_forced,
  output logic [FRAME_COUNT_BITS-1:0]   frame_count
);

  localparam int PW = 3 + 4*OFFSET_BITS + 4*COEFF_BITS;
  localparam logic [COEFF_BITS-1:0] UNITY = COEFF_BITS'(1 << COEFF_Q);
  localparam logic [PW-1:0] INIT_PARAM = {INIT_ENABLE, 2'b00, {(4*OFFSET_BITS){1'b0}}, {4{UNITY}}};

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                        state_q, state_d;
  logic [PW-1:0]                 shadow_q, shadow_d;
  logic [PW-1:0]                 live_q, live_d;
  logic                          ack_q, ack_d;
  logic                          forced_q, forced_d;
  logic [FRAME_COUNT_BITS-1:0]   frame_count_q, frame_count_d;
  logic [PW-1:0]                 req_vec;
  logic                          frame_start;
  logic                          apply;
  logic                          timeout_hit;

  assign frame_start = cke & img_valid & img_row_first & img_col_first;
  assign req_vec     = {s_enable, s_phase, s_offset, s_coeff};

`ifdef JELLY3_IMG_WB_PARAM_CTL_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (timeout != '0) && (tmo_cnt_q == timeout - TIMEOUT_BITS'(1));

  // Counts only while staying in PENDING; any fresh req restarts the wait.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == PENDING && state_d == PENDING && !s_update_req) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = &{1'b0, timeout};
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A req in the apply cycle makes shadow_d the new values, so they go straight to live.
  always_comb begin
    state_d  = state_q;
    apply    = 1'b0;
    forced_d = 1'b0;
    shadow_d = s_update_req ? req_vec : shadow_q;
    case (state_q)
      IDLE: begin
        if (s_update_req && s_update_mode == 2'd0) begin
          state_d = PENDING;
        end else if (s_update_req && s_update_mode == 2'd1) begin
          apply = 1'b1;
        end else if (frame_start && s_update_mode == 2'd2) begin
          apply = 1'b1;
        end
      end
      PENDING: begin
        if (frame_start) begin
          apply   = 1'b1;
          state_d = IDLE;
        end else if (s_update_req) begin
          state_d = PENDING;
        end else if (timeout_hit) begin
          apply    = 1'b1;
          forced_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    live_d        = apply ? shadow_d : live_q;
    ack_d         = apply;
    frame_count_d = frame_count_q + FRAME_COUNT_BITS'(frame_start);
    update_busy   = (state_q == PENDING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= INIT_PARAM;
      live_q        <= INIT_PARAM;
      ack_q         <= 1'b0;
      forced_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      shadow_q      <= shadow_d;
      live_q        <= live_d;
      ack_q         <= ack_d;
      forced_q      <= forced_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign {m_enable, m_phase, m_offset, m_coeff} = live_q;
  assign update_ack    = ack_q;
  assign update_forced = forced_q;
  assign frame_count   = frame_count_q;

endmodule
